mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (16-bit memory word, 32-bit address, 32-bit requester data).
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  fetch request; held with if_addr until if_ack.
REQ-005 if_addr  in  32  fetch word address; always a 32-bit read.
REQ-006 if_ack  out  1  one-cycle pulse; if_rdata valid in that cycle.
REQ-007 if_rdata  out  32  fetched data, held until next fetch ack.
REQ-008 d_req  in  1  data request; held with d_we/d_size/d_addr/d_wdata until d_ack.
REQ-009 d_we  in  1  1 = write, 0 = read.
REQ-010 d_size  in  1  0 = 16-bit (one word), 1 = 32-bit (two words).
REQ-011 d_addr  in  32  data word address.
REQ-012 d_wdata  in  32  write data; 16-bit writes use [15:0].
REQ-013 d_ack  out  1  one-cycle completion pulse.
REQ-014 d_rdata  out  32  read data; 16-bit reads zero-extend.
REQ-015 busy  out  1  high in every non-IDLE state.
REQ-016 mem_read_enable, mem_write_enable  out  1 each  memory strobes.
REQ-017 mem_read_addr, mem_write_addr  out  32 each  memory addresses.
REQ-018 mem_write_data  out  16  memory write word.
REQ-019 mem_read_data  in  16  memory read word, registered by memory on posedge after mem_read_enable.

Function
REQ-020 FSM states SHALL be IDLE, RD_LO, RD_HI, RD_FIN, WR_LO, WR_HI; memory-side outputs SHALL be decoded from registered state/address/data only (Moore), stable for the whole cycle including the negedge write.
REQ-021 IDLE SHALL sample requests; granted read -> RD_LO, granted write -> WR_LO; no request -> stay IDLE.
REQ-022 Word order SHALL be little-endian: addr A = bits [15:0], A+1 = bits [31:16]; A+1 SHALL wrap 32'hFFFFFFFF -> 0.
REQ-023 RD_LO: mem_read_enable=1, addr A; next RD_HI if 32-bit else RD_FIN.
REQ-024 RD_HI: mem_read_enable=1, addr A+1, capture mem_read_data (word A) into lo register; next RD_FIN.
REQ-025 RD_FIN: strobes 0; at its end register rdata ({mem_read_data, lo} for 32-bit, {16'b0, mem_read_data} for 16-bit) and pulse the granted ack; next IDLE.
REQ-026 Read latency: request sampled at edge e0 -> ack visible 4 cycles later (32-bit), 3 cycles later (16-bit).
REQ-027 WR_LO: mem_write_enable=1, addr A, data d_wdata[15:0]; WR_HI: addr A+1, data d_wdata[31:16]; ack registered at end of final write state; next IDLE. Latency 3 (32-bit), 2 (16-bit).
REQ-028 mem_read_enable and mem_write_enable SHALL never be high together; both 0 in IDLE and RD_FIN.
REQ-029 A requester whose ack is high in the current cycle SHALL NOT be granted in that cycle.
REQ-030 Inputs of the non-granted requester SHALL be ignored until its grant; no request is ever dropped except by reset.
REQ-031 Fetch requests are always reads; d_we/d_size are ignored for fetch.

Reset
REQ-032 On rst at a posedge: state=IDLE, all acks 0, busy 0, memory strobes 0, rdata/lo/address/data registers 0, last-grant = fetch.
REQ-033 Reset mid-transaction SHALL abort it with no ack; a write word already strobed is not undone.

Configuration
REQ-034 MEM_ARB_ROUND_ROBIN_EN defined: with both requests pending in IDLE, grant the requester not granted last (first contention after reset -> data).
REQ-035 MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, data always wins contention; last-grant register absent.

Verification
REQ-036 Preload M[0x10]=0x1111, M[0x11]=0x2222; if_req addr 0x10 -> if_rdata=0x22221111, if_ack exactly 4 cycles after request sampled.
REQ-037 d_req write 32-bit 0xDEADBEEF at 0x20, then 16-bit read 0x21 -> M[0x20]=0xBEEF, M[0x21]=0xDEAD, d_rdata=0x0000DEAD, ack latencies 3 and 3.
REQ-038 if_req and d_req both held continuously -> fixed priority: data served repeatedly, fetch starved; round-robin: grants alternate D,F,D,F.
REQ-039 32-bit read at 0xFFFFFFFF -> second read address 0x00000000.
REQ-040 Assert rst during RD_HI of a fetch -> next cycle IDLE, strobes 0, no if_ack; re-issued fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one 16-bit-wide synchronous memory port between an instruction
// fetch requester (always 32-bit reads) and a data requester (16/32-bit
// reads and writes). A 32-bit access is split into two word accesses,
// little-endian: word A holds bits [15:0], word A+1 holds bits [31:16].
// Address A+1 wraps naturally from 32'hFFFF_FFFF to 32'h0000_0000.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> on contention grant the requester
//                                        that was not granted last (first
//                                        contention after reset -> data).
//                           undefined -> fixed priority, data always wins.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   if_req/if_addr    fetch request + word address, held until if_ack
//   if_ack/if_rdata   one-cycle completion pulse, fetched data (held)
//   d_req/d_we/d_size/d_addr/d_wdata
//                     data request, held until d_ack; d_size 0=16b, 1=32b
//   d_ack/d_rdata     one-cycle completion pulse, read data (held,
//                     16-bit reads zero-extended)
//   busy              high whenever the FSM is not IDLE
//   mem_read_enable/mem_read_addr    memory read strobe and address
//   mem_write_enable/mem_write_addr/mem_write_data
//                     memory write strobe, address and word
//   mem_read_data     memory read word, registered by the memory on the
//                     posedge after mem_read_enable
// ---------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic        busy,

    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_LO  = 3'd1;
    localparam logic [2:0] RD_HI  = 3'd2;
    localparam logic [2:0] RD_FIN = 3'd3;
    localparam logic [2:0] WR_LO  = 3'd4;
    localparam logic [2:0] WR_HI  = 3'd5;

    logic [2:0]  state;
    logic [2:0]  state_next;

    // Registered copy of the granted request; the memory side is decoded
    // only from these, so the requester may change its inputs freely once
    // it has been granted without disturbing the memory strobes.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wide_q;
    logic        owner_data_q;
    logic [15:0] lo_q;

    logic        grant_any;
    logic        grant_data;
    logic        grant_we;
    logic        grant_wide;
    logic [31:0] grant_addr;

    logic        ack_cycle;
    logic        read_done;
    logic        write_done;
    logic [31:0] rdata_word;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 when the most recent grant went to the data requester.
    logic        last_grant_data;
`endif

    // While either ack is high the arbiter is in its turnaround cycle and
    // grants nobody. The just-finished requester still has its request
    // asserted in this cycle (it only sees the ack now), so granting it
    // would replay the transaction; skipping the cycle altogether also
    // keeps the priority rule deterministic for requesters that hold
    // their request continuously.
    assign ack_cycle = if_ack | d_ack;

    // Arbitration: only evaluated in IDLE outside the turnaround cycle.
    always_comb begin
        grant_any  = 1'b0;
        grant_data = 1'b0;
        if (state == IDLE && !ack_cycle) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (d_req && if_req) begin
                grant_any  = 1'b1;
                grant_data = !last_grant_data;
            end else if (d_req) begin
                grant_any  = 1'b1;
                grant_data = 1'b1;
            end else if (if_req) begin
                grant_any  = 1'b1;
                grant_data = 1'b0;
            end
`else
            if (d_req) begin
                grant_any  = 1'b1;
                grant_data = 1'b1;
            end else if (if_req) begin
                grant_any  = 1'b1;
                grant_data = 1'b0;
            end
`endif
        end
    end

    // Attributes of the winning request. Fetches are always 32-bit reads,
    // so d_we/d_size only matter when the data side wins.
    always_comb begin
        grant_we   = grant_data & d_we;
        grant_wide = grant_data ? d_size : 1'b1;
        grant_addr = grant_data ? d_addr : if_addr;
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = grant_we ? WR_LO : RD_LO;
                end
            end
            RD_LO:   state_next = wide_q ? RD_HI : RD_FIN;
            RD_HI:   state_next = RD_FIN;
            RD_FIN:  state_next = IDLE;
            WR_LO:   state_next = wide_q ? WR_HI : IDLE;
            WR_HI:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the latched request. lo_q grabs word A during
    // RD_HI: that is the cycle in which the memory presents the word
    // addressed in RD_LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wide_q       <= 1'b0;
            owner_data_q <= 1'b0;
            lo_q         <= 16'h0;
        end else begin
            state <= state_next;
            if (grant_any) begin
                addr_q       <= grant_addr;
                wdata_q      <= grant_data ? d_wdata : 32'h0;
                wide_q       <= grant_wide;
                owner_data_q <= grant_data;
            end
            if (state == RD_HI) begin
                lo_q <= mem_read_data;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who won last so contention alternates. Reset value "fetch"
    // makes the first contention after reset go to the data requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_data <= 1'b0;
        end else if (grant_any) begin
            last_grant_data <= grant_data;
        end
    end
`endif

    // Completion decode. A 16-bit write finishes in WR_LO; every read
    // finishes in RD_FIN, where the memory is presenting the last word.
    always_comb begin
        read_done  = (state == RD_FIN);
        write_done = (state == WR_HI) || (state == WR_LO && !wide_q);
        rdata_word = wide_q ? {mem_read_data, lo_q} : {16'h0, mem_read_data};
    end

    // Ack pulses and read-data holding registers. Each requester's rdata
    // only changes on its own read completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= 32'h0;
            d_rdata  <= 32'h0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (read_done) begin
                if (owner_data_q) begin
                    d_ack   <= 1'b1;
                    d_rdata <= rdata_word;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= rdata_word;
                end
            end
            if (write_done) begin
                d_ack <= 1'b1;
            end
        end
    end

    // Memory-side outputs are a pure decode of registered state, so they
    // hold steady for the whole cycle, including the memory's negedge
    // write. The high word always lives at addr_q + 1 (wraps at 2^32).
    always_comb begin
        busy             = (state != IDLE);
        mem_read_enable  = (state == RD_LO) || (state == RD_HI);
        mem_write_enable = (state == WR_LO) || (state == WR_HI);
        mem_read_addr    = (state == RD_HI) ? addr_q + 32'd1 : addr_q;
        mem_write_addr   = (state == WR_HI) ? addr_q + 32'd1 : addr_q;
        mem_write_data   = (state == WR_HI) ? wdata_q[31:16] : wdata_q[15:0];
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. Contains a 16-bit synchronous memory model
// (registered read on posedge, write on negedge) and a separate word-level
// reference memory. Expected read data, write results and ack latencies
// are derived from the transaction rules: 32-bit = {M[A+1], M[A]},
// 16-bit read = {0, M[A]}; latency counted in negedges after the request
// is driven, i.e. read32 4, read16 3, write32 3, write16 2.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TIMEOUT = 60;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic        d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        busy;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_write_addr;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    int check_cnt;
    int pass_cnt;

    logic [15:0] mem     [logic [31:0]];
    logic [15:0] ref_mem [logic [31:0]];

    logic        mon_en;
    int          strobe_violations;
    logic        log_rd;
    logic [31:0] rd_addrs [$];

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_ack           (if_ack),
        .if_rdata         (if_rdata),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_size           (d_size),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_ack            (d_ack),
        .d_rdata          (d_rdata),
        .busy             (busy),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_read_addr    (mem_read_addr),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 16'h0;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    // Memory model: registered read data, negedge write.
    initial mem_read_data = 16'h0;
    always @(posedge clk) begin
        if (mem_read_enable === 1'b1) mem_read_data <= mem_rd(mem_read_addr);
    end
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) mem[mem_write_addr] = mem_write_data;
    end

    // Strobe watcher: both strobes together, or any strobe while idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_read_enable === 1'b1 && mem_write_enable === 1'b1)
                strobe_violations++;
            if (busy === 1'b0 && (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0))
                strobe_violations++;
            if (log_rd && mem_read_enable === 1'b1)
                rd_addrs.push_back(mem_read_addr);
        end
    end

    task automatic preload(input logic [31:0] a, input logic [15:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one fetch and wait for its ack; lat = -1 on timeout.
    task automatic do_fetch(input logic [31:0] a, output logic [31:0] rd, output int lat);
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = a;
        lat = -1;
        rd  = 32'h0;
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(negedge clk);
            if (if_ack === 1'b1) begin
                lat = n;
                rd  = if_rdata;
                break;
            end
        end
        if_req = 1'b0;
    endtask

    // Issue one data transaction and wait for its ack; lat = -1 on timeout.
    task automatic do_data(input logic we, input logic sz, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = we;
        d_size  = sz;
        d_addr  = a;
        d_wdata = wd;
        lat = -1;
        rd  = 32'h0;
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(negedge clk);
            if (d_ack === 1'b1) begin
                lat = n;
                rd  = d_rdata;
                break;
            end
        end
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_cnt++;
        if ({if_ack, d_ack} !== 2'b00)
            $display("[TB] FAIL reset_acks: got %b expected 00", {if_ack, d_ack});
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0)
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        check_cnt++;
        if ({mem_read_enable, mem_write_enable} !== 2'b00)
            $display("[TB] FAIL reset_strobes: got %b expected 00", {mem_read_enable, mem_write_enable});
        else pass_cnt++;
        check_cnt++;
        if ({if_rdata, d_rdata} !== 64'h0)
            $display("[TB] FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        else pass_cnt++;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_fetch_basic();
        logic [31:0] rd;
        int lat;
        preload(32'h10, 16'h1111);
        preload(32'h11, 16'h2222);
        do_fetch(32'h10, rd, lat);
        check_cnt++;
        if (rd !== 32'h22221111)
            $display("[TB] FAIL fetch_data: got %h expected 22221111", rd);
        else pass_cnt++;
        check_cnt++;
        if (lat !== 4)
            $display("[TB] FAIL fetch_latency: got %0d expected 4", lat);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat;
        do_data(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, rd, lat);
        check_cnt++;
        if (lat !== 3)
            $display("[TB] FAIL write32_latency: got %0d expected 3", lat);
        else pass_cnt++;
        ref_mem[32'h20] = 16'hBEEF;
        ref_mem[32'h21] = 16'hDEAD;
        check_cnt++;
        if ({mem_rd(32'h21), mem_rd(32'h20)} !== {ref_rd(32'h21), ref_rd(32'h20)})
            $display("[TB] FAIL write32_mem: got %h expected %h",
                     {mem_rd(32'h21), mem_rd(32'h20)}, {ref_rd(32'h21), ref_rd(32'h20)});
        else pass_cnt++;
        do_data(1'b0, 1'b0, 32'h21, 32'hFFFFFFFF, rd, lat);
        check_cnt++;
        if (rd !== 32'h0000DEAD)
            $display("[TB] FAIL read16_data: got %h expected 0000dead", rd);
        else pass_cnt++;
        check_cnt++;
        if (lat !== 3)
            $display("[TB] FAIL read16_latency: got %0d expected 3", lat);
        else pass_cnt++;
        do_data(1'b1, 1'b0, 32'h22, 32'h1234CAFE, rd, lat);
        ref_mem[32'h22] = 16'hCAFE;
        check_cnt++;
        if (lat !== 2)
            $display("[TB] FAIL write16_latency: got %0d expected 2", lat);
        else pass_cnt++;
        check_cnt++;
        if (mem_rd(32'h23) !== ref_rd(32'h23) || mem_rd(32'h22) !== 16'hCAFE)
            $display("[TB] FAIL write16_mem: got %h expected %h",
                     {mem_rd(32'h23), mem_rd(32'h22)}, {ref_rd(32'h23), 16'hCAFE});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int lat;
        preload(32'hFFFFFFFF, 16'hAAAA);
        preload(32'h00000000, 16'h5555);
        rd_addrs.delete();
        log_rd = 1'b1;
        do_data(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, rd, lat);
        log_rd = 1'b0;
        check_cnt++;
        if (rd !== 32'h5555AAAA)
            $display("[TB] FAIL wrap_data: got %h expected 5555aaaa", rd);
        else pass_cnt++;
        check_cnt++;
        if (rd_addrs.size() != 2)
            $display("[TB] FAIL wrap_read_count: got %0d expected 2", rd_addrs.size());
        else if (rd_addrs[0] !== 32'hFFFFFFFF || rd_addrs[1] !== 32'h0)
            $display("[TB] FAIL wrap_addrs: got %h,%h expected ffffffff,00000000",
                     rd_addrs[0], rd_addrs[1]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        we;
        logic        sz;
        int          lat;
        int          exp_lat;
        int          kind;
        for (int i = 0; i < 17; i++)
            preload(32'h100 + i, 16'($urandom));
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 2));
            a    = 32'h100 + 32'($urandom_range(0, 15));
            wd   = $urandom;
            if (kind == 0) begin
                exp_rd  = {ref_rd(a + 1), ref_rd(a)};
                exp_lat = 4;
                do_fetch(a, rd, lat);
                check_cnt++;
                if (rd !== exp_rd || lat !== exp_lat)
                    $display("[TB] FAIL rand_fetch[%0d]: got %h/%0d expected %h/%0d",
                             i, rd, lat, exp_rd, exp_lat);
                else pass_cnt++;
            end else begin
                we = $urandom_range(0, 1) == 1;
                sz = $urandom_range(0, 1) == 1;
                if (we) begin
                    exp_lat = sz ? 3 : 2;
                    ref_mem[a] = wd[15:0];
                    if (sz) ref_mem[a + 1] = wd[31:16];
                    do_data(1'b1, sz, a, wd, rd, lat);
                    check_cnt++;
                    if (lat !== exp_lat)
                        $display("[TB] FAIL rand_write[%0d]: got lat %0d expected %0d", i, lat, exp_lat);
                    else pass_cnt++;
                end else begin
                    exp_lat = sz ? 4 : 3;
                    exp_rd  = sz ? {ref_rd(a + 1), ref_rd(a)} : {16'h0, ref_rd(a)};
                    do_data(1'b0, sz, a, wd, rd, lat);
                    check_cnt++;
                    if (rd !== exp_rd || lat !== exp_lat)
                        $display("[TB] FAIL rand_read[%0d]: got %h/%0d expected %h/%0d",
                                 i, rd, lat, exp_rd, exp_lat);
                    else pass_cnt++;
                end
            end
        end
        for (int i = 0; i < 17; i++) begin
            check_cnt++;
            if (mem_rd(32'h100 + i) !== ref_rd(32'h100 + i))
                $display("[TB] FAIL rand_mem[%0d]: got %h expected %h",
                         i, mem_rd(32'h100 + i), ref_rd(32'h100 + i));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        int lat;
        int stray;
        preload(32'h300, 16'h0BAD);
        preload(32'h301, 16'hF00D);
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        check_cnt++;
        if (mem_read_enable !== 1'b1 || mem_read_addr !== 32'h301)
            $display("[TB] FAIL abort_in_rd_hi: got %b/%h expected 1/00000301",
                     mem_read_enable, mem_read_addr);
        else pass_cnt++;
        rst    = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({busy, mem_read_enable, mem_write_enable, if_ack} !== 4'b0000)
            $display("[TB] FAIL abort_idle: got %b expected 0000",
                     {busy, mem_read_enable, mem_write_enable, if_ack});
        else pass_cnt++;
        rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (if_ack === 1'b1) stray++;
        end
        check_cnt++;
        if (stray != 0)
            $display("[TB] FAIL abort_no_ack: got %0d acks expected 0", stray);
        else pass_cnt++;
        do_fetch(32'h300, rd, lat);
        check_cnt++;
        if (rd !== 32'hF00D0BAD || lat !== 4)
            $display("[TB] FAIL abort_refetch: got %h/%0d expected f00d0bad/4", rd, lat);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        logic        grants [6];
        logic [31:0] dvals  [6];
        logic        exp_g;
        int          n_got;
        apply_reset();
        preload(32'h40, 16'h7777);
        preload(32'h41, 16'h8888);
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h40;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_size  = 1'b0;
        d_addr  = 32'h41;
        n_got   = 0;
        for (int c = 0; c < 100 && n_got < 6; c++) begin
            @(negedge clk);
            if (d_ack === 1'b1 && n_got < 6) begin
                grants[n_got] = 1'b1;
                dvals[n_got]  = d_rdata;
                n_got++;
            end
            if (if_ack === 1'b1 && n_got < 6) begin
                grants[n_got] = 1'b0;
                dvals[n_got]  = if_rdata;
                n_got++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check_cnt++;
        if (n_got != 6)
            $display("[TB] FAIL contention_count: got %0d acks expected 6", n_got);
        else pass_cnt++;
        for (int i = 0; i < n_got; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0);
`else
            exp_g = 1'b1;
`endif
            check_cnt++;
            if (grants[i] !== exp_g)
                $display("[TB] FAIL contention_grant[%0d]: got %s expected %s",
                         i, grants[i] ? "D" : "F", exp_g ? "D" : "F");
            else if (dvals[i] !== (exp_g ? {16'h0, ref_rd(32'h41)}
                                         : {ref_rd(32'h41), ref_rd(32'h40)}))
                $display("[TB] FAIL contention_data[%0d]: got %h", i, dvals[i]);
            else pass_cnt++;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_strobes();
        check_cnt++;
        if (strobe_violations != 0)
            $display("[TB] FAIL strobe_rules: got %0d violations expected 0", strobe_violations);
        else pass_cnt++;
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        strobe_violations = 0;
        mon_en  = 1'b0;
        log_rd  = 1'b0;
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        test_reset();
        test_fetch_basic();
        test_write_read();
        test_wrap();
        test_random();
        test_reset_abort();
        test_contention();
        test_strobes();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
